multicycle_control: RTL and testbench



---
 rtl/multicycle_control_pkg.sv | 74 +++++++
 rtl/mc_output_decode.sv | 93 +++++++++
 rtl/multicycle_control.sv | 102 ++++++++++
 tb/tb_multicycle_control.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: opcodes, state
// encodings, datapath select encodings and the control word layout.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_EXEC_R    = 4'd6,
      ST_EXEC_I    = 4'd7,
      ST_EXEC_U    = 4'd8,
      ST_ALU_WB    = 4'd9,
      ST_BRANCH    = 4'd10,
      ST_JAL       = 4'd11,
      ST_JALR_ADDR = 4'd12,
      ST_HALT      = 4'd13
   } state_t;

   localparam logic [6:0] OP_R       = 7'b0110011;
   localparam logic [6:0] OP_ARITH_I = 7'b0010011;
   localparam logic [6:0] OP_LOAD_I  = 7'b0000011;
   localparam logic [6:0] OP_S       = 7'b0100011;
   localparam logic [6:0] OP_B       = 7'b1100011;
   localparam logic [6:0] OP_J       = 7'b1101111;
   localparam logic [6:0] OP_JUMP_I  = 7'b1100111;
   localparam logic [6:0] OP_LOAD_U  = 7'b0110111;
   localparam logic [6:0] OP_ADD_U   = 7'b0010111;
   localparam logic [6:0] OP_ENV_I   = 7'b1110011;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [1:0] SRC_A_RS1    = 2'b10;
   localparam logic [1:0] SRC_A_ZERO   = 2'b11;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_IMM  = 2'b01;
   localparam logic [1:0] SRC_B_FOUR = 2'b10;

   localparam logic [1:0] ALU_OP_ADD    = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
   localparam logic [1:0] ALU_OP_UPPER  = 2'b11;

   localparam logic [1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [1:0] RES_MEM_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU_RESULT = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       illegal;
      logic       halted;
   } ctrl_t;

   function automatic logic opcode_known(input logic [6:0] opcode);
      case (opcode)
         OP_R, OP_ARITH_I, OP_LOAD_I, OP_S, OP_B, OP_J,
         OP_JUMP_I, OP_LOAD_U, OP_ADD_U, OP_ENV_I: opcode_known = 1'b1;
         default:                                  opcode_known = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode for the multi-cycle FSM: Moore selects
// per state, with only the memory and branch strobes gated by live inputs.
module mc_output_decode
   import multicycle_control_pkg::*;
(
   input  state_t     state,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         ST_FETCH: begin
            ctrl.mem_req    = 1'b1;
            ctrl.ir_write   = mem_ready;
            ctrl.pc_write   = mem_ready;
            ctrl.alu_src_a  = SRC_A_PC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.alu_op     = ALU_OP_ADD;
            ctrl.result_src = RES_ALU_RESULT;
         end
         // ALUOut captures the branch/JAL target while the opcode is inspected.
         ST_DECODE: begin
            ctrl.alu_src_a = SRC_A_OLD_PC;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.illegal   = !opcode_known(opcode);
         end
         ST_MEM_ADDR, ST_JALR_ADDR: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         ST_MEM_READ: begin
            ctrl.mem_req = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_MEM_DATA;
         end
         ST_MEM_WRITE: begin
            ctrl.mem_req = 1'b1;
            ctrl.mem_we  = 1'b1;
            ctrl.adr_src = 1'b1;
         end
         ST_EXEC_R: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         ST_EXEC_I: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_FUNCT;
         end
         ST_EXEC_U: begin
            ctrl.alu_src_a = (opcode == OP_LOAD_U) ? SRC_A_ZERO : SRC_A_OLD_PC;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_UPPER;
         end
         ST_ALU_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RES_ALU_OUT;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a  = SRC_A_RS1;
            ctrl.alu_src_b  = SRC_B_RS2;
            ctrl.alu_op     = ALU_OP_BRANCH;
            ctrl.result_src = RES_ALU_OUT;
            ctrl.pc_write   = branch_taken;
         end
         // PC takes the target held in ALUOut while the ALU forms the link value.
         ST_JAL: begin
            ctrl.pc_write   = 1'b1;
            ctrl.result_src = RES_ALU_OUT;
            ctrl.alu_src_a  = SRC_A_OLD_PC;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.alu_op     = ALU_OP_ADD;
         end
         ST_HALT: begin
            ctrl.halted = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: state register and
// next-state logic, with the control word produced by mc_output_decode.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter bit HALT_ON_ENV = 1'b1
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic [31:0] in_instruction,
   input  logic        in_mem_ready,
   input  logic        in_branch_taken,
   output logic        out_mem_req,
   output logic        out_mem_we,
   output logic        out_adr_src,
   output logic        out_ir_write,
   output logic        out_pc_write,
   output logic        out_reg_write,
   output logic [1:0]  out_alu_src_a,
   output logic [1:0]  out_alu_src_b,
   output logic [1:0]  out_alu_op,
   output logic [1:0]  out_result_src,
   output logic        out_illegal,
   output logic        out_halted,
   output logic [3:0]  out_state
);

   state_t     state;
   state_t     state_next;
   logic [6:0] opcode;
   ctrl_t      ctrl;
   ctrl_t      ctrl_gated;
   logic       unused_instr_bits;

   assign opcode            = in_instruction[6:0];
   assign unused_instr_bits = ^in_instruction[31:7];

   always_ff @(posedge in_clk) begin
      if (in_rst) state <= ST_FETCH;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH:     if (in_mem_ready) state_next = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_R:                state_next = ST_EXEC_R;
               OP_ARITH_I:          state_next = ST_EXEC_I;
               OP_LOAD_I, OP_S:     state_next = ST_MEM_ADDR;
               OP_B:                state_next = ST_BRANCH;
               OP_J:                state_next = ST_JAL;
               OP_JUMP_I:           state_next = ST_JALR_ADDR;
               OP_LOAD_U, OP_ADD_U: state_next = ST_EXEC_U;
               OP_ENV_I:            state_next = HALT_ON_ENV ? ST_HALT : ST_FETCH;
               default:             state_next = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR:  state_next = (opcode == OP_LOAD_I) ? ST_MEM_READ : ST_MEM_WRITE;
         ST_MEM_READ:  if (in_mem_ready) state_next = ST_MEM_WB;
         ST_MEM_WB:    state_next = ST_FETCH;
         ST_MEM_WRITE: if (in_mem_ready) state_next = ST_FETCH;
         ST_EXEC_R,
         ST_EXEC_I,
         ST_EXEC_U:    state_next = ST_ALU_WB;
         ST_ALU_WB:    state_next = ST_FETCH;
         ST_BRANCH:    state_next = ST_FETCH;
         ST_JAL:       state_next = ST_ALU_WB;
         ST_JALR_ADDR: state_next = ST_JAL;
         ST_HALT:      state_next = ST_HALT;
         default:      state_next = ST_FETCH;
      endcase
   end

   mc_output_decode u_output_decode (
      .state        (state),
      .opcode       (opcode),
      .mem_ready    (in_mem_ready),
      .branch_taken (in_branch_taken),
      .ctrl         (ctrl)
   );

   // Reset overrides everything combinationally so no request or strobe leaks
   // out in the cycle an in-flight instruction is abandoned.
   assign ctrl_gated = in_rst ? '0 : ctrl;

   assign out_mem_req    = ctrl_gated.mem_req;
   assign out_mem_we     = ctrl_gated.mem_we;
   assign out_adr_src    = ctrl_gated.adr_src;
   assign out_ir_write   = ctrl_gated.ir_write;
   assign out_pc_write   = ctrl_gated.pc_write;
   assign out_reg_write  = ctrl_gated.reg_write;
   assign out_alu_src_a  = ctrl_gated.alu_src_a;
   assign out_alu_src_b  = ctrl_gated.alu_src_b;
   assign out_alu_op     = ctrl_gated.alu_op;
   assign out_result_src = ctrl_gated.result_src;
   assign out_illegal    = ctrl_gated.illegal;
   assign out_halted     = ctrl_gated.halted;
   assign out_state      = in_rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: per-cycle input/expected records
// go through a scoreboard queue and are compared on the falling edge.
module tb_multicycle_control;

   typedef struct packed {
      logic       req;
      logic       we;
      logic       adr;
      logic       irw;
      logic       pcw;
      logic       regw;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] op;
      logic [1:0] res;
      logic       ill;
      logic       halt;
   } ctl_t;

   typedef struct {
      logic        rst;
      logic [31:0] instr;
      logic        ready;
      logic        taken;
      logic [3:0]  st;
      ctl_t        ctl;
   } vec_t;

   typedef struct {
      logic [3:0] st;
      ctl_t       ctl;
      int         idx;
   } exp_t;

   localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MADDR = 4'd2,
                          S_MREAD = 4'd3,  S_MWB    = 4'd4,  S_MWRITE = 4'd5,
                          S_EXR   = 4'd6,  S_EXI    = 4'd7,  S_EXU    = 4'd8,
                          S_ALUWB = 4'd9,  S_BRANCH = 4'd10, S_JAL    = 4'd11,
                          S_JALR  = 4'd12, S_HALT   = 4'd13;
   localparam logic [1:0] A_PC = 2'd0, A_OLD = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3;
   localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
   localparam logic [1:0] R_OUT = 2'd0, R_MEM = 2'd1, R_RES = 2'd2;

   localparam logic [31:0] I_ADDI  = 32'h00500093;
   localparam logic [31:0] I_LW    = 32'h0000A103;
   localparam logic [31:0] I_SW    = 32'h0020A223;
   localparam logic [31:0] I_BEQ   = 32'h00000463;
   localparam logic [31:0] I_JAL   = 32'h010000EF;
   localparam logic [31:0] I_JALR  = 32'h00008067;
   localparam logic [31:0] I_LUI   = 32'h123450B7;
   localparam logic [31:0] I_AUIPC = 32'h00001097;
   localparam logic [31:0] I_ECALL = 32'h00000073;
   localparam logic [31:0] I_BAD   = 32'h0000007F;
   localparam logic [31:0] I_ADD   = 32'h002081B3;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        ready;
   logic        taken;
   logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
   logic        illegal, halted;
   logic [3:0]  state;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   vec_count = 0;

   multicycle_control #(.HALT_ON_ENV(1'b1)) dut (
      .in_clk          (clk),
      .in_rst          (rst),
      .in_instruction  (instr),
      .in_mem_ready    (ready),
      .in_branch_taken (taken),
      .out_mem_req     (mem_req),
      .out_mem_we      (mem_we),
      .out_adr_src     (adr_src),
      .out_ir_write    (ir_write),
      .out_pc_write    (pc_write),
      .out_reg_write   (reg_write),
      .out_alu_src_a   (alu_src_a),
      .out_alu_src_b   (alu_src_b),
      .out_alu_op      (alu_op),
      .out_result_src  (result_src),
      .out_illegal     (illegal),
      .out_halted      (halted),
      .out_state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctl_t mk(input logic rq, input logic w, input logic ad,
                               input logic ir, input logic pc, input logic rw,
                               input logic [1:0] sa, input logic [1:0] sb_,
                               input logic [1:0] o, input logic [1:0] rs,
                               input logic il, input logic h);
      ctl_t c;
      c.req = rq; c.we = w; c.adr = ad; c.irw = ir; c.pcw = pc; c.regw = rw;
      c.a = sa; c.b = sb_; c.op = o; c.res = rs; c.ill = il; c.halt = h;
      return c;
   endfunction

   task automatic addVec(input logic r, input logic [31:0] i, input logic rd,
                         input logic tk, input logic [3:0] s, input ctl_t c);
      vec_t v;
      v.rst = r; v.instr = i; v.ready = rd; v.taken = tk; v.st = s; v.ctl = c;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      rst   = v.rst;
      instr = v.instr;
      ready = v.ready;
      taken = v.taken;
      e.st  = v.st;
      e.ctl = v.ctl;
      e.idx = vec_count;
      vec_count++;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      ctl_t act;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_empty got=0 want=1");
         return;
      end
      e = sb.pop_front();
      act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src, illegal, halted};
      total++;
      if (state !== e.st) begin
         bad++;
         $display("[TB] FAIL state[%0d] got=%0d want=%0d", e.idx, state, e.st);
      end
      total++;
      if (act !== e.ctl) begin
         bad++;
         $display("[TB] FAIL ctrl[%0d] got=%h want=%h", e.idx, act, e.ctl);
      end
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ctl_t z;
      ctl_t fetch_rdy, fetch_wait, dec, wb;
      vec_t v;
      z          = '0;
      fetch_rdy  = mk(1,0,0,1,1,0, A_PC,  B_FOUR, 2'd0, R_RES, 0,0);
      fetch_wait = mk(1,0,0,0,0,0, A_PC,  B_FOUR, 2'd0, R_RES, 0,0);
      dec        = mk(0,0,0,0,0,0, A_OLD, B_IMM,  2'd0, R_OUT, 0,0);
      wb         = mk(0,0,0,0,0,1, A_PC,  B_RS2,  2'd0, R_OUT, 0,0);

      // reset held two cycles, outputs all zero even with ready/taken high
      addVec(1, I_ADDI, 1, 1, S_FETCH, z);
      addVec(1, I_ADDI, 1, 1, S_FETCH, z);
      // addi: 4 cycles, taken high in EXEC_I must not leak into pc_write
      addVec(0, I_ADDI, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_ADDI, 1, 0, S_DECODE, dec);
      addVec(0, I_ADDI, 1, 1, S_EXI,    mk(0,0,0,0,0,0, A_RS1, B_IMM, 2'd2, R_OUT, 0,0));
      addVec(0, I_ADDI, 1, 0, S_ALUWB,  wb);
      // lw with three wait cycles in MEM_READ: MEM_WB on cycle 8
      addVec(0, I_LW, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_LW, 0, 0, S_DECODE, dec);
      addVec(0, I_LW, 1, 0, S_MADDR,  mk(0,0,0,0,0,0, A_RS1, B_IMM, 2'd0, R_OUT, 0,0));
      addVec(0, I_LW, 0, 0, S_MREAD,  mk(1,0,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0));
      addVec(0, I_LW, 0, 0, S_MREAD,  mk(1,0,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0));
      addVec(0, I_LW, 0, 0, S_MREAD,  mk(1,0,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0));
      addVec(0, I_LW, 1, 0, S_MREAD,  mk(1,0,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0));
      addVec(0, I_LW, 1, 0, S_MWB,    mk(0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, R_MEM, 0,0));
      // sw with one fetch wait cycle
      addVec(0, I_SW, 0, 0, S_FETCH,  fetch_wait);
      addVec(0, I_SW, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_SW, 1, 0, S_DECODE, dec);
      addVec(0, I_SW, 1, 0, S_MADDR,  mk(0,0,0,0,0,0, A_RS1, B_IMM, 2'd0, R_OUT, 0,0));
      addVec(0, I_SW, 1, 0, S_MWRITE, mk(1,1,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0));
      // beq taken then not taken
      addVec(0, I_BEQ, 1, 1, S_FETCH,  fetch_rdy);
      addVec(0, I_BEQ, 1, 1, S_DECODE, dec);
      addVec(0, I_BEQ, 1, 1, S_BRANCH, mk(0,0,0,0,1,0, A_RS1, B_RS2, 2'd1, R_OUT, 0,0));
      addVec(0, I_BEQ, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_BEQ, 1, 0, S_DECODE, dec);
      addVec(0, I_BEQ, 1, 0, S_BRANCH, mk(0,0,0,0,0,0, A_RS1, B_RS2, 2'd1, R_OUT, 0,0));
      // jal
      addVec(0, I_JAL, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_JAL, 1, 0, S_DECODE, dec);
      addVec(0, I_JAL, 1, 0, S_JAL,    mk(0,0,0,0,1,0, A_OLD, B_FOUR, 2'd0, R_OUT, 0,0));
      addVec(0, I_JAL, 1, 0, S_ALUWB,  wb);
      // jalr: 5 cycles through JALR_ADDR then JAL
      addVec(0, I_JALR, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_JALR, 1, 0, S_DECODE, dec);
      addVec(0, I_JALR, 1, 0, S_JALR,   mk(0,0,0,0,0,0, A_RS1, B_IMM, 2'd0, R_OUT, 0,0));
      addVec(0, I_JALR, 1, 0, S_JAL,    mk(0,0,0,0,1,0, A_OLD, B_FOUR, 2'd0, R_OUT, 0,0));
      addVec(0, I_JALR, 1, 0, S_ALUWB,  wb);
      // lui and auipc differ only in the A select
      addVec(0, I_LUI, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_LUI, 1, 0, S_DECODE, dec);
      addVec(0, I_LUI, 1, 0, S_EXU,    mk(0,0,0,0,0,0, A_ZERO, B_IMM, 2'd3, R_OUT, 0,0));
      addVec(0, I_LUI, 1, 0, S_ALUWB,  wb);
      addVec(0, I_AUIPC, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_AUIPC, 1, 0, S_DECODE, dec);
      addVec(0, I_AUIPC, 1, 0, S_EXU,    mk(0,0,0,0,0,0, A_OLD, B_IMM, 2'd3, R_OUT, 0,0));
      addVec(0, I_AUIPC, 1, 0, S_ALUWB,  wb);
      // R-type add
      addVec(0, I_ADD, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_ADD, 1, 0, S_DECODE, dec);
      addVec(0, I_ADD, 1, 0, S_EXR,    mk(0,0,0,0,0,0, A_RS1, B_RS2, 2'd2, R_OUT, 0,0));
      addVec(0, I_ADD, 1, 0, S_ALUWB,  wb);
      // unknown opcode pulses illegal and returns to FETCH
      addVec(0, I_BAD, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_BAD, 1, 0, S_DECODE, mk(0,0,0,0,0,0, A_OLD, B_IMM, 2'd0, R_OUT, 1,0));
      addVec(0, I_BAD, 0, 0, S_FETCH,  fetch_wait);
      // reset while MEM_WRITE is waiting: nothing escapes, then FETCH
      addVec(0, I_SW, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_SW, 1, 0, S_DECODE, dec);
      addVec(0, I_SW, 0, 0, S_MADDR,  mk(0,0,0,0,0,0, A_RS1, B_IMM, 2'd0, R_OUT, 0,0));
      addVec(0, I_SW, 0, 0, S_MWRITE, mk(1,1,1,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,0));
      addVec(1, I_SW, 1, 1, S_FETCH,  z);
      addVec(0, I_SW, 0, 0, S_FETCH,  fetch_wait);
      // ecall leads into HALT
      addVec(0, I_ECALL, 1, 0, S_FETCH,  fetch_rdy);
      addVec(0, I_ECALL, 1, 0, S_DECODE, dec);

      rst = 1'b1; instr = '0; ready = 1'b0; taken = 1'b0;
      foreach (vecs[i]) runVec(vecs[i]);

      // HALT is sticky for 100 cycles whatever memory and branch inputs do
      for (int k = 0; k < 100; k++) begin
         v.rst = 1'b0; v.instr = I_ECALL;
         v.ready = 1'($urandom_range(0, 1));
         v.taken = 1'($urandom_range(0, 1));
         v.st = S_HALT;
         v.ctl = mk(0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 2'd0, 0,1);
         runVec(v);
      end
      // only reset leaves HALT
      v.rst = 1'b1; v.ready = 1'b1; v.taken = 1'b1; v.st = S_FETCH; v.ctl = z;
      runVec(v);
      v.rst = 1'b0; v.instr = I_ADDI; v.ready = 1'b1; v.taken = 1'b0;
      v.st = S_FETCH; v.ctl = fetch_rdy;
      runVec(v);
      v.ready = 1'b0; v.st = S_DECODE; v.ctl = dec;
      runVec(v);

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
